pwm_capture: RTL and testbench

Measures an external PWM waveform and recovers its duty cycle as a `WIDTH`-bit level. It is the receive-side counterpart of the `pwm` generator: a `pwm` instance of the same `WIDTH` running at any period up to `TIMEOUT` is decoded back to the level that drove it. It sits behind a PMOD input pin in `top` and feeds the recovered level to LED/debug logic.

---
 rtl/pwm_capture.sv | 160 ++++++++++++++++
 tb/tb_pwm_capture.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM duty-cycle capture with serial restoring divider
module pwm_capture #(
    parameter int   WIDTH   = 8,
    parameter int   CNT_W   = 16,
    parameter int   TIMEOUT = 1024,
    parameter logic INVERT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             pwm_in,
    output logic [WIDTH-1:0] level,
    output logic             valid,
    output logic             stuck,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             dropped
);

    localparam int              IW      = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] C_ALL1 = '1;
    localparam logic [CNT_W-1:0] C_TMO  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] C_TMO1 = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE,
        S_MEASURE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_sig_d;
    logic             w_sig;
    logic             w_rise;
    logic             w_edge;
    logic             w_timeout;
    logic             w_latch;
    logic             w_drop;

    logic [CNT_W-1:0] r_p_cnt;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_t_cnt;

    logic             r_busy;
    logic [IW-1:0]    r_iter;
    logic [CNT_W:0]   r_rem;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_hi;
    logic [WIDTH-2:0] r_quo;
    logic             r_sat;
    logic [CNT_W+1:0] w_shift;
    logic [CNT_W:0]   w_diff;
    logic             w_ge;

    assign w_sig     = r_sync2 ^ INVERT;
    assign w_rise    = w_sig & ~r_sig_d;
    assign w_edge    = w_sig ^ r_sig_d;
    assign w_timeout = !w_edge && (r_t_cnt == C_TMO1);

    // One restoring step: shift, compare against the latched period, subtract.
    assign w_shift = {r_rem, 1'b0};
    assign w_ge    = (w_shift >= {2'b00, r_div});
    assign w_diff  = w_shift[CNT_W:0] - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sig_d <= 1'b0;
            r_p_cnt <= '0;
            r_h_cnt <= '0;
            r_t_cnt <= '0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
            r_sig_d <= w_sig;
            if (w_rise) begin
                r_p_cnt <= C_ONE;
                r_h_cnt <= C_ONE;
            end else begin
                if (r_p_cnt != C_ALL1) r_p_cnt <= r_p_cnt + C_ONE;
                if (w_sig && (r_h_cnt != C_ALL1)) r_h_cnt <= r_h_cnt + C_ONE;
            end
            if (w_edge) r_t_cnt <= '0;
            else if (r_t_cnt != C_TMO) r_t_cnt <= r_t_cnt + C_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_latch      = 1'b0;
        w_drop       = 1'b0;
        if (w_timeout) begin
            w_state_next = S_IDLE;
        end else if (w_rise) begin
            w_state_next = S_MEASURE;
            if (r_state == S_MEASURE) begin
                if (r_busy)               w_drop  = 1'b1;
                else if (r_p_cnt != '0)   w_latch = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy    <= 1'b0;
            r_iter    <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_hi      <= '0;
            r_quo     <= '0;
            r_sat     <= 1'b0;
            level     <= '0;
            valid     <= 1'b0;
            stuck     <= 1'b0;
            period    <= '0;
            high_time <= '0;
            dropped   <= 1'b0;
        end else begin
            valid   <= 1'b0;
            dropped <= w_drop;
            if (w_latch) begin
                r_busy <= 1'b1;
                r_iter <= IW'(WIDTH);
                r_rem  <= {1'b0, r_h_cnt};
                r_div  <= r_p_cnt;
                r_hi   <= r_h_cnt;
                r_quo  <= '0;
                r_sat  <= (r_h_cnt >= r_p_cnt);
            end else if (r_busy) begin
                r_rem  <= w_ge ? w_diff : w_shift[CNT_W:0];
                r_quo  <= {r_quo[WIDTH-3:0], w_ge};
                r_iter <= r_iter - IW'(1);
                if (r_iter == IW'(1)) begin
                    r_busy    <= 1'b0;
                    valid     <= 1'b1;
                    stuck     <= 1'b0;
                    level     <= r_sat ? '1 : {r_quo, w_ge};
                    period    <= r_div;
                    high_time <= r_hi;
                end
            end
            // Static input: report the held level once, keep the last measurement.
            if (w_timeout) begin
                valid <= 1'b1;
                stuck <= 1'b1;
                level <= w_sig ? '1 : '0;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture
module tb_pwm_capture;

    localparam int W   = 8;
    localparam int CW  = 16;
    localparam int TMO = 1024;

    typedef struct {
        int cyc;
        int lvl;
        int per;
        int hi;
        int stk;
    } exp_t;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          pwm_in  = 1'b0;
    logic          pin_inv;
    logic [W-1:0]  level,     i_level;
    logic          valid,     i_valid;
    logic          stuck,     i_stuck;
    logic [CW-1:0] period,    i_period;
    logic [CW-1:0] high_time, i_high_time;
    logic          dropped,   i_dropped;

    assign pin_inv = ~pwm_in;

    pwm_capture #(.WIDTH(W), .CNT_W(CW), .TIMEOUT(TMO), .INVERT(1'b0)) u_dut (
        .clk(clk), .reset_n(reset_n), .pwm_in(pwm_in),
        .level(level), .valid(valid), .stuck(stuck),
        .period(period), .high_time(high_time), .dropped(dropped)
    );

    pwm_capture #(.WIDTH(W), .CNT_W(CW), .TIMEOUT(TMO), .INVERT(1'b1)) u_inv (
        .clk(clk), .reset_n(reset_n), .pwm_in(pin_inv),
        .level(i_level), .valid(i_valid), .stuck(i_stuck),
        .period(i_period), .high_time(i_high_time), .dropped(i_dropped)
    );

    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb[$];
    exp_t sb_inv[$];
    int   dq[$];
    bit   inv_track = 1'b0;

    bit   m_prev;
    bit   m_meas;
    int   m_last_edge, m_last_rise, m_busy_free, m_hcnt, m_last_p, m_last_h;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int exp_level(input int hi, input int per);
        return (hi >= per) ? (1 << W) - 1 : (hi * (1 << W)) / per;
    endfunction

    task automatic cmp_result(input string who, input exp_t e, input int lvl,
                              input int per, input int hi, input int stk);
        chk({who, "_cycle"},     cyc, e.cyc);
        chk({who, "_level"},     lvl, e.lvl);
        chk({who, "_period"},    per, e.per);
        chk({who, "_high_time"}, hi,  e.hi);
        chk({who, "_stuck"},     stk, e.stk);
    endtask

    // Pin value driven in cycle k is seen as sig in cycle k+2.
    task automatic model_step(input int k, input bit v);
        exp_t x;
        int   e;
        e = k + 2;
        if (e == m_last_edge + TMO + 1) begin
            x.cyc = e; x.lvl = m_prev ? (1 << W) - 1 : 0;
            x.per = m_last_p; x.hi = m_last_h; x.stk = 1;
            sb.push_back(x);
            m_meas = 1'b0;
        end
        if (v != m_prev) begin
            m_last_edge = e;
            if (v) begin
                if (m_meas) begin
                    if (e >= m_busy_free) begin
                        x.cyc = e + W + 1; x.per = e - m_last_rise; x.hi = m_hcnt;
                        x.lvl = exp_level(x.hi, x.per); x.stk = 0;
                        sb.push_back(x);
                        if (inv_track) sb_inv.push_back(x);
                        m_last_p = x.per; m_last_h = x.hi;
                        m_busy_free = e + W + 1;
                    end else begin
                        dq.push_back(e + 1);
                    end
                end
                m_meas = 1'b1; m_last_rise = e; m_hcnt = 0;
            end
        end
        if (v) m_hcnt++;
        m_prev = v;
    endtask

    task automatic drive(input bit v);
        pwm_in = v;
        model_step(cyc, v);
        @(posedge clk); #1;
    endtask

    task automatic run_part(input int p, input int h, input int n);
        for (int i = 0; i < n; i++) drive((i % p) < h);
    endtask

    task automatic run(input int p, input int h, input int nper);
        run_part(p, h, p * nper);
    endtask

    task automatic hold(input bit v, input int n);
        for (int i = 0; i < n; i++) drive(v);
    endtask

    task automatic do_reset(input bit v, input int n_low);
        reset_n = 1'b0;
        pwm_in  = v;
        repeat (n_low) begin @(posedge clk); #1; end
        sb.delete(); sb_inv.delete(); dq.delete();
        m_prev = 1'b0; m_meas = 1'b0; m_last_edge = cyc - 1; m_last_rise = 0;
        m_busy_free = 0; m_hcnt = 0; m_last_p = 0; m_last_h = 0;
        chk("rst_level",     int'(level),     0);
        chk("rst_valid",     int'(valid),     0);
        chk("rst_stuck",     int'(stuck),     0);
        chk("rst_period",    int'(period),    0);
        chk("rst_high_time", int'(high_time), 0);
        chk("rst_dropped",   int'(dropped),   0);
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0 && sb[0].cyc < cyc) begin
            chk("main_missed_valid", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (valid === 1'b1) begin
            if (sb.size() == 0) chk("main_unexpected_valid", int'(valid), 0);
            else cmp_result("main", sb.pop_front(), int'(level), int'(period),
                            int'(high_time), int'(stuck));
        end
        if (dq.size() != 0 && dq[0] < cyc) begin
            chk("dropped_missed", cyc, dq[0]);
            void'(dq.pop_front());
        end
        if (dropped === 1'b1) begin
            if (dq.size() == 0) chk("unexpected_dropped", int'(dropped), 0);
            else chk("dropped_cycle", cyc, dq.pop_front());
        end
        if (sb_inv.size() != 0 && sb_inv[0].cyc < cyc) begin
            chk("inv_missed_valid", cyc, sb_inv[0].cyc);
            void'(sb_inv.pop_front());
        end
        if (i_valid === 1'b1 && (inv_track || sb_inv.size() != 0)) begin
            if (sb_inv.size() == 0) chk("inv_unexpected_valid", int'(i_valid), 0);
            else cmp_result("inv", sb_inv.pop_front(), int'(i_level), int'(i_period),
                            int'(i_high_time), int'(i_stuck));
        end
    end

    initial begin
        do_reset(1'b0, 4);
        run(256, 64, 6);
        run(256, 255, 3);
        run(256, 1, 3);
        hold(1'b0, 2000);
        inv_track = 1'b1;
        run(256, 200, 4);
        run(1000, 250, 3);
        inv_track = 1'b0;
        hold(1'b1, 2000);
        run(5, 2, 12);
        run(256, 64, 2);
        run_part(256, 64, 6);
        do_reset(1'b1, 1);
        run(256, 64, 3);
        hold(1'b0, 1100);
        chk("main_queue_empty", sb.size(), 0);
        chk("inv_queue_empty", sb_inv.size(), 0);
        chk("drop_queue_empty", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
